mmm_pow_seq: RTL and testbench

Constant-time left-to-right modular-exponentiation sequencer that computes x^e mod p by issuing Montgomery products to an external pipelined MMM core and consuming its results. It sits between the crypto top level and the MMM core and acts as the requester side of the core's operand/result interface. The modulus and the reduction constant (m_b) are wired from the top level directly to the core and do not pass through this block. The block is agnostic to the Montgomery radix R: the caller supplies R^2 mod p and R mod p.

---
 rtl/mmm_pow_pkg.sv | 39 +++
 rtl/mmm_pow_seq_exp_scan.sv | 53 +++++
 rtl/mmm_pow_seq.sv | 213 +++++++++++++++++++++
 tb/tb_mmm_pow_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pow_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
// Holds the FSM state enum and the operand-select encoding used to build
// Montgomery requests. It also holds the default widths and the core latency
// shared with the MMM core and the crypto top level.
package mmm_pow_pkg;

  localparam int WIDTH_DEF = 256;
  localparam int EW_DEF    = 256;
  localparam int LAT_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    TOM,
    SQ,
    MUL,
    FROMM,
    DONE
  } state_e;

  // Operand pairs sent to the core:
  //   XR2 = (x, r2), AA = (acc, acc), AX = (acc, xm), A1 = (acc, 1)
  typedef enum logic [1:0] {
    XR2,
    AA,
    AX,
    A1
  } op_sel_e;

  // Every request-issuing state maps to exactly one operand pair.
  function automatic op_sel_e sel_of(state_e s);
    case (s)
      TOM:     return XR2;
      SQ:      return AA;
      MUL:     return AX;
      default: return A1;
    endcase
  endfunction

endpackage

// File: rtl/mmm_pow_seq_exp_scan.sv
// Exponent scanner for the left-to-right ladder.
// The scanner holds the exponent in a shift register. The bit under
// consideration is always the MSB, and a down-counter marks the final bit.
// Ports:
//   clk, rstn    clock, async active-low reset
//   i_load       capture i_e and set the counter to EW-1
//   i_shift      advance to the next lower exponent bit
//   i_e          exponent to capture
//   o_cur_bit    current exponent bit e[cnt]
//   o_last       high while the counter is at bit 0
module mmm_pow_seq_exp_scan #(
  parameter int EW = 256
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic [EW-1:0] i_e,
  output logic          o_cur_bit,
  output logic          o_last
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;

  logic [EW-1:0] e_q, e_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (i_load) begin
      e_d   = i_e;
      cnt_d = CW'(EW - 1);
    end else if (i_shift) begin
      e_d   = e_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_cur_bit = e_q[EW-1];
  assign o_last    = (cnt_q == '0);

endmodule

// File: rtl/mmm_pow_seq.sv
// Constant-time left-to-right modular exponentiation sequencer (x^e mod p).
// The block drives an external pipelined Montgomery multiplier (MMM) core.
// It always issues 2*EW+2 products regardless of e: to-Montgomery, EW
// square/multiply pairs, and from-Montgomery. The multiply result is
// discarded when the exponent bit is 0. At most one request is outstanding.
// Ports:
//   clk, rstn           clock, async active-low reset
//   i_start             start pulse, only honoured in IDLE
//   i_x, i_e            base (< p) and exponent
//   i_r2, i_one_m       R^2 mod p and R mod p for the core's radix
//   o_busy, o_done      run in progress / one-cycle completion pulse
//   o_res               x^e mod p, held until the next completion
//   o_err               sticky flag for a response with nothing outstanding
//   o_mm_vld/a/b        request strobe and operands to the core
//   i_mm_vld/res        response strobe and product a*b*R^-1 mod p
module mmm_pow_seq
  import mmm_pow_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int EW    = EW_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [EW-1:0]    i_e,
  input  logic [WIDTH-1:0] i_r2,
  input  logic [WIDTH-1:0] i_one_m,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res,
  output logic             o_err,
  output logic             o_mm_vld,
  output logic [WIDTH-1:0] o_mm_a,
  output logic [WIDTH-1:0] o_mm_b,
  input  logic             i_mm_vld,
  input  logic [WIDTH-1:0] i_mm_res
);

  // The sequencer is purely handshake-driven. Core latency matters only to
  // the surrounding system, so any value >= 1 is acceptable here.
  if (LAT < 1) begin : g_lat_unsupported
  end

  state_e           state_q, state_d;
  logic             out_q, out_d;       // one request outstanding
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] one_q, one_d;
  logic [WIDTH-1:0] xm_q, xm_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mm_vld_q, mm_vld_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d;
  logic [WIDTH-1:0] mm_b_q, mm_b_d;

  logic             issue;
  logic             scan_load, scan_shift;
  logic             cur_bit, last;

  mmm_pow_seq_exp_scan #(.EW(EW)) u_scan (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (scan_load),
    .i_shift   (scan_shift),
    .i_e       (i_e),
    .o_cur_bit (cur_bit),
    .o_last    (last)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    x_d        = x_q;
    r2_d       = r2_q;
    one_d      = one_q;
    xm_d       = xm_q;
    acc_d      = acc_q;
    res_d      = res_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    mm_vld_d   = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    issue      = 1'b0;
    scan_load  = 1'b0;
    scan_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          x_d       = i_x;
          r2_d      = i_r2;
          one_d     = i_one_m;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          out_d     = 1'b0;
          scan_load = 1'b1;
          state_d   = TOM;
        end
      end
      TOM, SQ, MUL, FROMM: begin
        if (!out_q) begin
          // First request of a run: operands come from the latched inputs,
          // so it goes out one cycle after start acceptance.
          issue = 1'b1;
        end else if (i_mm_vld) begin
          out_d = 1'b0;
          case (state_q)
            TOM: begin
              xm_d    = i_mm_res;
              acc_d   = one_q;
              state_d = SQ;
              issue   = 1'b1;
            end
            SQ: begin
              acc_d   = i_mm_res;
              state_d = MUL;
              issue   = 1'b1;
            end
            MUL: begin
              // Always multiply and keep the product only for set bits, so
              // timing does not depend on the exponent.
              if (cur_bit) acc_d = i_mm_res;
              if (last) begin
                state_d = FROMM;
              end else begin
                scan_shift = 1'b1;
                state_d    = SQ;
              end
              issue = 1'b1;
            end
            default: begin
              res_d   = i_mm_res;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = DONE;
            end
          endcase
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A response with nothing in flight is flagged and otherwise ignored.
    if (i_mm_vld && !out_q) err_d = 1'b1;

    // The next request is built from the just-updated acc/xm. This lets it
    // leave on the same edge that consumes the previous response.
    if (issue) begin
      mm_vld_d = 1'b1;
      out_d    = 1'b1;
      case (sel_of(state_d))
        XR2: begin mm_a_d = x_q;   mm_b_d = r2_q;  end
        AA:  begin mm_a_d = acc_d; mm_b_d = acc_d; end
        AX:  begin mm_a_d = acc_d; mm_b_d = xm_d;  end
        default: begin mm_a_d = acc_d; mm_b_d = WIDTH'(1); end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      out_q    <= 1'b0;
      x_q      <= '0;
      r2_q     <= '0;
      one_q    <= '0;
      xm_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mm_vld_q <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      x_q      <= x_d;
      r2_q     <= r2_d;
      one_q    <= one_d;
      xm_q     <= xm_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mm_vld_q <= mm_vld_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_res    = res_q;
  assign o_err    = err_q;
  assign o_mm_vld = mm_vld_q;
  assign o_mm_a   = mm_a_q;
  assign o_mm_b   = mm_b_q;

endmodule

// File: tb/tb_mmm_pow_seq.sv
// Bench for mmm_pow_seq. It contains a behavioural MMM core with a fixed
// latency, p = 2^256 - 2^32 - 977 and R = 2^259. Directed runs are compared
// against hand-computed results and a reference modular pow.
module tb_mmm_pow_seq;
  import mmm_pow_pkg::*;

  localparam int W        = 256;
  localparam int EW       = 256;
  localparam int LAT      = 16;
  localparam int NREQ     = 2 * EW + 2;
  localparam int DONE_CYC = NREQ * (LAT + 1) + 1;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start;
  logic [W-1:0]  i_x, i_r2, i_one_m;
  logic [EW-1:0] i_e;
  logic          o_busy, o_done, o_err, o_mm_vld;
  logic [W-1:0]  o_res, o_mm_a, o_mm_b;
  logic          i_mm_vld;
  logic [W-1:0]  i_mm_res;

  int errs   = 0;
  int checks = 0;
  logic [W-1:0] rinv;
  logic          inj = 1'b0;

  always #5 clk = ~clk;

  mmm_pow_seq #(.WIDTH(W), .EW(EW), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_x(i_x), .i_e(i_e),
    .i_r2(i_r2), .i_one_m(i_one_m), .o_busy(o_busy), .o_done(o_done),
    .o_res(o_res), .o_err(o_err), .o_mm_vld(o_mm_vld), .o_mm_a(o_mm_a),
    .o_mm_b(o_mm_b), .i_mm_vld(i_mm_vld), .i_mm_res(i_mm_res)
  );

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    t = t % {{W{1'b0}}, P};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    return mulmod(mulmod(a, b), rinv);
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [EW-1:0] e);
    logic [W-1:0] r;
    r = W'(1);
    for (int i = EW - 1; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, x);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Behavioural core: fixed-latency pipeline; not reset, like a real core
  // that keeps draining while the sequencer is held in reset.
  bit           pv [LAT];
  bit [W-1:0]   pr [LAT];
  always @(posedge clk) begin
    pv[0] <= o_mm_vld;
    pr[0] <= o_mm_vld ? mont(o_mm_a, o_mm_b) : '0;
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign i_mm_vld = pv[LAT-1] | inj;
  assign i_mm_res = pr[LAT-1];

  int req_cnt  = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (o_mm_vld) req_cnt <= req_cnt + 1;
    if (o_done)   done_cnt <= done_cnt + 1;
  end

  // One full run. t0 is the edge that accepts i_start; cyc counts edges after it.
  task automatic run_op(input logic [W-1:0] x, input logic [EW-1:0] e, input bit disturb,
                        output logic [W-1:0] res, output logic [W-1:0] res_hold,
                        output int reqs, output int cyc, output int dones,
                        output bit busy_mid, output bit busy_end, output bit to);
    int r0, d0;
    @(negedge clk);
    i_x = x; i_e = e; i_start = 1'b1;
    r0 = req_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 0; busy_mid = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) busy_mid = o_busy;
      if (disturb && cyc == 100) begin
        i_start = 1'b1; i_x = x + W'(7); i_e = ~e;
      end
      if (disturb && cyc == 101) i_start = 1'b0;
    end while (!o_done && cyc < DONE_CYC + 50);
    to = !o_done;
    res = o_res;
    busy_end = o_busy;
    repeat (3) @(posedge clk);
    #1;
    res_hold = o_res;
    reqs  = req_cnt - r0;
    dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_start = 1'b0; i_x = '0; i_e = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_err, o_mm_vld} !== 4'b0 || o_res !== '0 ||
        o_mm_a !== '0 || o_mm_b !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b vld=%b res=%0h a=%0h b=%0h, expected all 0",
               o_busy, o_done, o_err, o_mm_vld, o_res, o_mm_a, o_mm_b);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] res, hold; int reqs, cyc, dones; bit bm, be, to;
    run_op(W'(3), EW'(5), 1'b0, res, hold, reqs, cyc, dones, bm, be, to);
    checks++; if (to) begin errs++; $display("FAIL basic_timeout: no o_done within %0d cycles", cyc); end
    checks++; if (res !== W'(243)) begin errs++; $display("FAIL basic_res: got %0h expected f3", res); end
    checks++; if (dones !== 1) begin errs++; $display("FAIL basic_done_pulses: got %0d expected 1", dones); end
    checks++; if (reqs !== NREQ) begin errs++; $display("FAIL basic_req_count: got %0d expected %0d", reqs, NREQ); end
    checks++; if (cyc !== DONE_CYC) begin errs++; $display("FAIL basic_done_cycle: got %0d expected %0d", cyc, DONE_CYC); end
    checks++; if (bm !== 1'b1 || be !== 1'b0) begin errs++; $display("FAIL basic_busy: got mid=%b end=%b expected 1/0", bm, be); end
    checks++; if (hold !== W'(243)) begin errs++; $display("FAIL basic_res_hold: got %0h expected f3", hold); end
    checks++; if (o_err !== 1'b0) begin errs++; $display("FAIL basic_err: got %b expected 0", o_err); end
  endtask

  task automatic test_small_exp();
    logic [W-1:0] res, hold; int reqs, cyc, dones; bit bm, be, to;
    run_op(W'(2), EW'(0), 1'b0, res, hold, reqs, cyc, dones, bm, be, to);
    checks++; if (to || res !== W'(1)) begin errs++; $display("FAIL exp0_res: got %0h (timeout=%b) expected 1", res, to); end
    checks++; if (reqs !== NREQ) begin errs++; $display("FAIL exp0_req_count: got %0d expected %0d", reqs, NREQ); end
    run_op(W'(16'h1234), EW'(1), 1'b0, res, hold, reqs, cyc, dones, bm, be, to);
    checks++; if (to || res !== W'(16'h1234)) begin errs++; $display("FAIL exp1_res: got %0h (timeout=%b) expected 1234", res, to); end
    checks++; if (cyc !== DONE_CYC) begin errs++; $display("FAIL exp1_done_cycle: got %0d expected %0d", cyc, DONE_CYC); end
  endtask

  task automatic test_pow_ref();
    logic [W-1:0] res, hold, x, exp_r; logic [EW-1:0] e; int reqs, cyc, dones; bit bm, be, to;
    run_op(P - W'(1), EW'(2), 1'b0, res, hold, reqs, cyc, dones, bm, be, to);
    checks++; if (to || res !== W'(1)) begin errs++; $display("FAIL pm1_sq_res: got %0h (timeout=%b) expected 1", res, to); end
    for (int n = 0; n < 2; n++) begin
      x = rnd256() % P;
      e = rnd256();
      exp_r = ref_pow(x, e);
      run_op(x, e, 1'b0, res, hold, reqs, cyc, dones, bm, be, to);
      checks++;
      if (to || res !== exp_r) begin
        errs++; $display("FAIL rand_pow_%0d: got %0h (timeout=%b) expected %0h", n, res, to, exp_r);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] res, hold; int reqs, cyc, dones; bit bm, be, to;
    run_op(W'(3), EW'(5), 1'b1, res, hold, reqs, cyc, dones, bm, be, to);
    checks++; if (to || res !== W'(243)) begin errs++; $display("FAIL restart_res: got %0h (timeout=%b) expected f3", res, to); end
    checks++; if (dones !== 1 || reqs !== NREQ) begin errs++; $display("FAIL restart_counts: got dones=%0d reqs=%0d expected 1/%0d", dones, reqs, NREQ); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] res, hold; int reqs, cyc, dones; bit bm, be, to;
    int r0, d0, n;
    @(negedge clk);
    i_x = W'(3); i_e = EW'(5); i_start = 1'b1; r0 = req_cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
    n = 0;
    while (req_cnt - r0 < 2 && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (req_cnt - r0 < 2) begin errs++; $display("FAIL rst_wait_sq: got %0d requests expected 2", req_cnt - r0); end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_err, o_mm_vld} !== 4'b0 || o_res !== '0 ||
        o_mm_a !== '0 || o_mm_b !== '0 || dut.state_q !== IDLE) begin
      errs++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b err=%b vld=%b res=%0h state=%0d, expected zeros/IDLE",
               o_busy, o_done, o_err, o_mm_vld, o_res, dut.state_q);
    end
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    while (!o_err && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (o_err !== 1'b1) begin errs++; $display("FAIL rst_stale_err: got %b expected 1", o_err); end
    checks++; if (done_cnt !== d0 || dut.state_q !== IDLE) begin errs++; $display("FAIL rst_stale_state: got dones=%0d state=%0d expected 0/IDLE", done_cnt - d0, dut.state_q); end
    run_op(W'(16'h1234), EW'(1), 1'b0, res, hold, reqs, cyc, dones, bm, be, to);
    checks++; if (to || res !== W'(16'h1234)) begin errs++; $display("FAIL rst_rerun_res: got %0h (timeout=%b) expected 1234", res, to); end
    checks++; if (o_err !== 1'b0) begin errs++; $display("FAIL rst_rerun_err: got %b expected 0", o_err); end
  endtask

  task automatic test_spurious();
    int d0;
    d0 = done_cnt;
    @(negedge clk); inj = 1'b1;
    @(negedge clk); inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_err !== 1'b1) begin errs++; $display("FAIL spur_err: got %b expected 1", o_err); end
    checks++; if (done_cnt !== d0 || o_busy !== 1'b0) begin errs++; $display("FAIL spur_done: got dones=%0d busy=%b expected 0/0", done_cnt - d0, o_busy); end
    checks++; if (o_res !== W'(16'h1234)) begin errs++; $display("FAIL spur_res: got %0h expected 1234", o_res); end
  endtask

  initial begin
    logic [W:0] t;
    // Radix constants: R mod p, R^2 mod p by modular doubling; R^-1 by halving.
    t = (W+1)'(1);
    for (int i = 0; i < 259; i++) begin
      t = t << 1;
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end
    i_one_m = t[W-1:0];
    for (int i = 0; i < 259; i++) begin
      t = t << 1;
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end
    i_r2 = t[W-1:0];
    t = (W+1)'(1);
    for (int i = 0; i < 259; i++) begin
      if (t[0]) t = t + {1'b0, P};
      t = t >> 1;
    end
    rinv = t[W-1:0];

    test_reset();
    test_basic();
    test_small_exp();
    test_pow_ref();
    test_start_ignored();
    test_reset_mid_run();
    test_spurious();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
